// File: rtl/llki_pkg.sv
// Shared LLKI definitions: host op, response and slave-command encodings,
// the 64-bit key word width, master FSM state codes and the registered
// slave-side request bundle (llki_s).
package llki_pkg;

  localparam int unsigned LLKI_WORD_W = 64;

  // Host operation encoding (host_op)
  localparam logic [1:0] OP_LOAD    = 2'd0;
  localparam logic [1:0] OP_CLEAR   = 2'd1;
  localparam logic [1:0] OP_STATUS  = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  // Host response encoding (rsp_code)
  localparam logic [1:0] RSP_OK         = 2'd0;
  localparam logic [1:0] RSP_TIMEOUT    = 2'd1;
  localparam logic [1:0] RSP_SLAVE_ERR  = 2'd2;
  localparam logic [1:0] RSP_ILLEGAL_OP = 2'd3;

  // Slave command encoding (llki_cmd)
  localparam logic [1:0] CMD_LOAD_WORD = 2'd0;
  localparam logic [1:0] CMD_CLEAR     = 2'd1;
  localparam logic [1:0] CMD_STATUS    = 2'd2;

  // Master FSM state codes
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ_HI = 2'd1;
  localparam logic [1:0] ST_REQ_LO = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Everything driven towards the discrete slave, registered as one unit
  typedef struct packed {
    logic                   req;
    logic [1:0]             cmd;
    logic [7:0]             idx;
    logic [LLKI_WORD_W-1:0] data;
  } llki_s;

  function automatic logic [1:0] op_to_cmd(input logic [1:0] op);
    case (op)
      OP_CLEAR:  op_to_cmd = CMD_CLEAR;
      OP_STATUS: op_to_cmd = CMD_STATUS;
      default:   op_to_cmd = CMD_LOAD_WORD;
    endcase
  endfunction

endpackage

// File: rtl/llki_timeout_ctr.sv
// Handshake-phase wait counter.
//   clk, rst : clock and synchronous active-high reset
//   clr      : restart the count (phase entry), wins over en
//   en       : a wait cycle is being spent in the current phase
//   expired  : this enabled cycle is the TIMEOUT_CYCLES-th of the phase
module llki_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // The counter holds the number of cycles already spent, so the phase is
  // over once the current cycle brings it to TIMEOUT_CYCLES.
  assign expired = en && (cnt_q == LIMIT);

endmodule

// File: rtl/llki_discrete_master.sv
// LLKI discrete master: accepts LOAD/CLEAR/STATUS requests from a host and
// runs four-phase req/ack handshakes with a discrete key slave.
//   clk, rst                : clock, synchronous active-high reset
//   host_valid/ready/op/key : host request channel (key latched on accept)
//   rsp_valid/code          : one-cycle completion pulse and result
//   rsp_key_present         : last slave-reported key status
//   llki_req/cmd/idx/data   : registered request to the slave
//   llki_ack/err/key_present: slave acknowledge and its status
module llki_discrete_master
  import llki_pkg::*;
#(
  parameter int unsigned KEY_WORDS      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            host_valid,
  output logic                            host_ready,
  input  logic [1:0]                      host_op,
  input  logic [KEY_WORDS*LLKI_WORD_W-1:0] host_key,
  output logic                            rsp_valid,
  output logic [1:0]                      rsp_code,
  output logic                            rsp_key_present,
  output logic                            llki_req,
  output logic [1:0]                      llki_cmd,
  output logic [7:0]                      llki_idx,
  output logic [LLKI_WORD_W-1:0]          llki_data,
  input  logic                            llki_ack,
  input  logic                            llki_err,
  input  logic                            llki_key_present
);

  localparam logic [7:0] LAST_IDX = 8'(KEY_WORDS - 1);

  logic [1:0]                       state_q, state_d;
  llki_s                            llki_q, llki_d;
  logic [1:0]                       op_q, op_d;
  logic [KEY_WORDS*LLKI_WORD_W-1:0] key_q, key_d;
  logic [7:0]                       idx_q, idx_d;
  logic                             err_q, err_d;
  logic                             kp_q, kp_d;
  logic [1:0]                       code_q, code_d;
  logic                             rsp_kp_q, rsp_kp_d;
  logic                             tmo_clr, tmo_en, tmo_expired;
  int unsigned                      word_base;

  assign host_ready = (state_q == ST_IDLE) && !llki_ack;

  always_comb begin
    state_d   = state_q;
    llki_d    = llki_q;
    op_d      = op_q;
    key_d     = key_q;
    idx_d     = idx_q;
    err_d     = err_q;
    kp_d      = kp_q;
    code_d    = code_q;
    rsp_kp_d  = rsp_kp_q;
    word_base = 0;
    case (state_q)
      ST_IDLE: begin
        if (host_valid && host_ready) begin
          op_d  = host_op;
          key_d = host_key;
          idx_d = '0;
          err_d = 1'b0;
          if (host_op == OP_ILLEGAL) begin
            code_d  = RSP_ILLEGAL_OP;
            state_d = ST_RESP;
          end else begin
            llki_d.req  = 1'b1;
            llki_d.cmd  = op_to_cmd(host_op);
            llki_d.idx  = '0;
            llki_d.data = (host_op == OP_LOAD) ? host_key[LLKI_WORD_W-1:0] : '0;
            state_d     = ST_REQ_HI;
          end
        end
      end
      ST_REQ_HI: begin
        // Ack wins over a same-cycle expiry: the handshake did complete.
        if (llki_ack) begin
          err_d   = llki_err;
          kp_d    = llki_key_present;
          llki_d  = '0;
          state_d = ST_REQ_LO;
        end else if (tmo_expired) begin
          llki_d  = '0;
          code_d  = RSP_TIMEOUT;
          state_d = ST_RESP;
        end
      end
      ST_REQ_LO: begin
        if (!llki_ack) begin
          rsp_kp_d = kp_q;
          if (err_q) begin
            code_d  = RSP_SLAVE_ERR;
            state_d = ST_RESP;
          end else if ((op_q == OP_LOAD) && (idx_q != LAST_IDX)) begin
            idx_d       = idx_q + 8'd1;
            word_base   = LLKI_WORD_W * 32'(idx_d);
            llki_d.req  = 1'b1;
            llki_d.cmd  = CMD_LOAD_WORD;
            llki_d.idx  = idx_d;
            llki_d.data = key_q[word_base +: LLKI_WORD_W];
            state_d     = ST_REQ_HI;
          end else begin
            code_d  = RSP_OK;
            state_d = ST_RESP;
          end
        end else if (tmo_expired) begin
          code_d  = RSP_TIMEOUT;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        key_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Restart on every phase entry, including REQ_LO -> REQ_HI between words.
  assign tmo_en  = (state_q == ST_REQ_HI) || (state_q == ST_REQ_LO);
  assign tmo_clr = ((state_d == ST_REQ_HI) && (state_q != ST_REQ_HI)) ||
                   ((state_d == ST_REQ_LO) && (state_q != ST_REQ_LO));

  llki_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      llki_q   <= '0;
      op_q     <= '0;
      key_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      kp_q     <= 1'b0;
      code_q   <= '0;
      rsp_kp_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      llki_q   <= llki_d;
      op_q     <= op_d;
      key_q    <= key_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      kp_q     <= kp_d;
      code_q   <= code_d;
      rsp_kp_q <= rsp_kp_d;
    end
  end

  assign rsp_valid       = (state_q == ST_RESP);
  assign rsp_code        = code_q;
  assign rsp_key_present = rsp_kp_q;
  assign llki_req        = llki_q.req;
  assign llki_cmd        = llki_q.cmd;
  assign llki_idx        = llki_q.idx;
  assign llki_data       = llki_q.data;

endmodule

// File: tb/tb_llki_discrete_master.sv
module tb_llki_discrete_master;
  import llki_pkg::*;

  localparam int unsigned KW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              host_valid = 1'b0;
  logic              host_ready;
  logic [1:0]        host_op = '0;
  logic [KW*64-1:0]  host_key = '0;
  logic              rsp_valid;
  logic [1:0]        rsp_code;
  logic              rsp_key_present;
  logic              llki_req;
  logic [1:0]        llki_cmd;
  logic [7:0]        llki_idx;
  logic [63:0]       llki_data;
  logic              llki_ack = 1'b0;
  logic              llki_err = 1'b0;
  logic              llki_key_present = 1'b0;

  llki_discrete_master #(
    .KEY_WORDS     (KW),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .host_valid      (host_valid),
    .host_ready      (host_ready),
    .host_op         (host_op),
    .host_key        (host_key),
    .rsp_valid       (rsp_valid),
    .rsp_code        (rsp_code),
    .rsp_key_present (rsp_key_present),
    .llki_req        (llki_req),
    .llki_cmd        (llki_cmd),
    .llki_idx        (llki_idx),
    .llki_data       (llki_data),
    .llki_ack        (llki_ack),
    .llki_err        (llki_err),
    .llki_key_present(llki_key_present)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cmd;
    logic [7:0]  idx;
    logic [63:0] data;
  } txn_t;

  typedef struct {
    logic [1:0] code;
    logic       kp;
  } rsp_t;

  txn_t exp_txn[$];
  rsp_t exp_rsp[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave model: acks two cycles after req rises, drops ack after req falls.
  bit slave_auto = 1'b0;
  bit err_idx0   = 1'b0;
  bit slave_kp   = 1'b0;
  int slave_dly  = 0;

  always @(negedge clk) begin
    if (slave_auto) begin
      if (llki_req && !llki_ack) begin
        slave_dly++;
        if (slave_dly >= 2) begin
          llki_ack         = 1'b1;
          llki_err         = err_idx0 && (llki_idx == 8'd0);
          llki_key_present = slave_kp;
          slave_dly        = 0;
        end
      end else if (!llki_req && llki_ack) begin
        llki_ack         = 1'b0;
        llki_err         = 1'b0;
        llki_key_present = 1'b0;
        slave_dly        = 0;
      end else if (!llki_req) begin
        slave_dly = 0;
      end
    end
  end

  // Monitor: request starts and responses are popped from the scoreboard.
  logic        prev_req  = 1'b0;
  logic [63:0] prev_data = '0;

  always @(negedge clk) begin
    txn_t t;
    rsp_t r;
    if (llki_req && !prev_req) begin
      chk("req_without_expect", 64'(exp_txn.size() == 0), 64'd0);
      if (exp_txn.size() != 0) begin
        t = exp_txn.pop_front();
        chk("llki_cmd", 64'(llki_cmd), 64'(t.cmd));
        chk("llki_idx", 64'(llki_idx), 64'(t.idx));
        chk("llki_data", llki_data, t.data);
      end
    end
    if (llki_req && prev_req) chk("req_hold_data", llki_data, prev_data);
    if (!llki_req) chk("data_zero_when_idle", llki_data, 64'd0);
    if (rsp_valid) begin
      chk("rsp_without_expect", 64'(exp_rsp.size() == 0), 64'd0);
      if (exp_rsp.size() != 0) begin
        r = exp_rsp.pop_front();
        chk("rsp_code", 64'(rsp_code), 64'(r.code));
        chk("rsp_key_present", 64'(rsp_key_present), 64'(r.kp));
      end
    end
    prev_req  <= llki_req;
    prev_data <= llki_data;
  end

  task automatic push_txn(input logic [1:0] cmd, input logic [7:0] idx, input logic [63:0] data);
    txn_t t;
    t.cmd = cmd; t.idx = idx; t.data = data;
    exp_txn.push_back(t);
  endtask

  task automatic push_rsp(input logic [1:0] code, input logic kp);
    rsp_t r;
    r.code = code; r.kp = kp;
    exp_rsp.push_back(r);
  endtask

  // Returns at the first negedge after the accepting posedge; the key on the
  // bus is then scrambled so any late sampling of host_key shows up.
  task automatic host_req(input logic [1:0] op, input logic [KW*64-1:0] key);
    int unsigned t = 0;
    @(negedge clk);
    host_valid = 1'b1;
    host_op    = op;
    host_key   = key;
    while (!host_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("host_accept_bound", 64'(t >= 100), 64'd0);
    @(negedge clk);
    host_valid = 1'b0;
    host_op    = '0;
    host_key   = ~key;
  endtask

  task automatic wait_rsp(input string tag);
    int unsigned t = 0;
    while (exp_rsp.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 64'(exp_rsp.size()), 64'd0);
  endtask

  localparam logic [127:0] KEY_A = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] KEY_B = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

  initial begin
    int unsigned hi_cnt;
    int unsigned t;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_llki_req", 64'(llki_req), 64'd0);
    chk("rst_llki_cmd", 64'(llki_cmd), 64'd0);
    chk("rst_llki_idx", 64'(llki_idx), 64'd0);
    chk("rst_llki_data", llki_data, 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_code", 64'(rsp_code), 64'd0);
    chk("rst_rsp_kp", 64'(rsp_key_present), 64'd0);
    chk("rst_host_ready", 64'(host_ready), 64'd1);
    rst = 1'b0;
    slave_auto = 1'b1;

    // LOAD of two words, ascending idx
    slave_kp = 1'b0;
    push_txn(CMD_LOAD_WORD, 8'd0, 64'hFEDCBA9876543210);
    push_txn(CMD_LOAD_WORD, 8'd1, 64'h0123456789ABCDEF);
    push_rsp(RSP_OK, 1'b0);
    host_req(OP_LOAD, KEY_A);
    wait_rsp("load_done");

    // STATUS reporting key present, then CLEAR reporting none
    slave_kp = 1'b1;
    push_txn(CMD_STATUS, 8'd0, 64'd0);
    push_rsp(RSP_OK, 1'b1);
    host_req(OP_STATUS, KEY_B);
    wait_rsp("status_done");

    slave_kp = 1'b0;
    push_txn(CMD_CLEAR, 8'd0, 64'd0);
    push_rsp(RSP_OK, 1'b0);
    host_req(OP_CLEAR, KEY_B);
    wait_rsp("clear_done");

    slave_kp = 1'b1;
    push_txn(CMD_STATUS, 8'd0, 64'd0);
    push_rsp(RSP_OK, 1'b1);
    host_req(OP_STATUS, '0);
    wait_rsp("status2_done");

    // Timeout: slave never acks; key-present must keep its last value
    slave_auto = 1'b0;
    push_txn(CMD_STATUS, 8'd0, 64'd0);
    push_rsp(RSP_TIMEOUT, 1'b1);
    host_req(OP_STATUS, '0);
    hi_cnt = 0;
    while (llki_req && hi_cnt < 50) begin
      hi_cnt++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", 64'(hi_cnt), 64'd10);
    wait_rsp("timeout_done");
    @(negedge clk);
    llki_ack         = 1'b1;
    llki_key_present = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_ack_blocks_ready", 64'(host_ready), 64'd0);
    chk("late_ack_kp_kept", 64'(rsp_key_present), 64'd1);
    llki_ack = 1'b0;
    @(negedge clk);
    chk("ready_after_late_ack", 64'(host_ready), 64'd1);

    // Slave error on idx0 aborts the LOAD
    slave_auto = 1'b1;
    err_idx0   = 1'b1;
    slave_kp   = 1'b0;
    push_txn(CMD_LOAD_WORD, 8'd0, KEY_B[63:0]);
    push_rsp(RSP_SLAVE_ERR, 1'b0);
    host_req(OP_LOAD, KEY_B);
    wait_rsp("err_done");
    repeat (5) @(negedge clk);
    err_idx0 = 1'b0;

    // Illegal op: response one cycle after acceptance, no slave traffic
    push_rsp(RSP_ILLEGAL_OP, 1'b0);
    host_req(OP_ILLEGAL, KEY_A);
    chk("illegal_rsp_timing", 64'(rsp_valid), 64'd1);
    wait_rsp("illegal_done");
    repeat (4) @(negedge clk);

    // Reset in REQ_HI: request dropped, no response
    slave_auto = 1'b0;
    push_txn(CMD_LOAD_WORD, 8'd0, KEY_A[63:0]);
    host_req(OP_LOAD, KEY_A);
    @(negedge clk);
    chk("pre_rst_req_high", 64'(llki_req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", 64'(llki_req), 64'd0);
    chk("mid_rst_data", llki_data, 64'd0);
    rst = 1'b0;
    t = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) t++;
    end
    chk("mid_rst_no_rsp", 64'(t), 64'd0);
    chk("mid_rst_kp_cleared", 64'(rsp_key_present), 64'd0);

    // Recovery LOAD after the mid-operation reset
    slave_auto = 1'b1;
    slave_kp   = 1'b1;
    push_txn(CMD_LOAD_WORD, 8'd0, KEY_B[63:0]);
    push_txn(CMD_LOAD_WORD, 8'd1, KEY_B[127:64]);
    push_rsp(RSP_OK, 1'b1);
    host_req(OP_LOAD, KEY_B);
    wait_rsp("recovery_done");

    repeat (6) @(negedge clk);
    chk("txn_queue_empty", 64'(exp_txn.size()), 64'd0);
    chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "simulation time limit");
  end

endmodule
